// File: rtl/xc2_addseq_pkg.sv
// Shared types and helpers for the byte-serial multi-precision adder sequencer.
// Optional subtract support is enabled by defining XC2_ADDSEQ_SUB_EN.
package xc2_addseq_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/xc2_addseq_if.sv
// Request/result handshake bundle for xc2_addseq.
// Carries req_sub only when XC2_ADDSEQ_SUB_EN is defined.
interface xc2_addseq_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
`ifdef XC2_ADDSEQ_SUB_EN
    logic         req_sub;
`endif
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin,
`ifdef XC2_ADDSEQ_SUB_EN
        output req_sub,
`endif
        output res_ready,
        input  req_ready, res_valid, res_sum, res_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
`ifdef XC2_ADDSEQ_SUB_EN
        input  req_sub,
`endif
        input  res_ready,
        output req_ready, res_valid, res_sum, res_cout
    );

endinterface

// File: rtl/xc2_add8.sv
// Combinational 8-bit ripple adder built from full-adder cells.
module xc2_add8
    import xc2_addseq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[BYTE_W];

endmodule

// File: rtl/xc2_addseq.sv
// Multi-precision add sequencer: one byte per clock through a shared 8-bit adder, LSB first.
// Define XC2_ADDSEQ_SUB_EN to add the req_sub (A-B) mode.
module xc2_addseq
    import xc2_addseq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    xc2_addseq_if.slave bus,
    output logic        busy
);

    localparam int unsigned CW = (clog2(NBYTES) < 1) ? 1 : clog2(NBYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

    typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    word_t         a_q, a_d;
    word_t         b_q, b_d;
    word_t         sum_q, sum_d;
    logic          cout_q, cout_d;

    logic [BYTE_W-1:0] add_s;
    logic              add_cout;

    xc2_add8 u_add8 (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    carry_d = bus.req_cin;
`ifdef XC2_ADDSEQ_SUB_EN
                    // Subtract as A + ~B + 1; B is stored already inverted.
                    if (bus.req_sub) begin
                        b_d     = ~bus.req_b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q] = add_s;
                carry_d      = add_cout;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = add_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_xc2_addseq.sv
// Bench for xc2_addseq: NBYTES=4 and NBYTES=1 instances against an arithmetic reference model.
// Subtract cases run when XC2_ADDSEQ_SUB_EN is defined.
module tb_xc2_addseq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xc2_addseq_if #(.NBYTES(4)) bus4 ();
    xc2_addseq_if #(.NBYTES(1)) bus1 ();
    logic busy4, busy1;

    xc2_addseq #(.NBYTES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4), .busy(busy4));
    xc2_addseq #(.NBYTES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1));

    // sel=0 drives/observes the 4-byte instance, sel=1 the 1-byte instance.
    logic        sel = 1'b0;
    logic        vld = 1'b0;
    logic        rdy = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    assign bus4.req_valid = vld & ~sel;
    assign bus1.req_valid = vld & sel;
    assign bus4.req_a     = a;
    assign bus1.req_a     = a[7:0];
    assign bus4.req_b     = b;
    assign bus1.req_b     = b[7:0];
    assign bus4.req_cin   = cin;
    assign bus1.req_cin   = cin;
    assign bus4.res_ready = rdy & ~sel;
    assign bus1.res_ready = rdy & sel;
`ifdef XC2_ADDSEQ_SUB_EN
    assign bus4.req_sub   = sub;
    assign bus1.req_sub   = sub;
`endif

    logic        o_valid, o_ready, o_busy, o_cout;
    logic [31:0] o_sum;
    assign o_valid = sel ? bus1.res_valid : bus4.res_valid;
    assign o_ready = sel ? bus1.req_ready : bus4.req_ready;
    assign o_busy  = sel ? busy1 : busy4;
    assign o_cout  = sel ? bus1.res_cout : bus4.res_cout;
    assign o_sum   = sel ? {24'd0, bus1.res_sum} : bus4.res_sum;

    int vecs  = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for result, optionally stall, then release.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                          input logic ts, input int hold);
        logic [31:0] mask, bb, exp_sum;
        logic [32:0] full;
        logic        exp_cout;
        int          n;
        mask     = sel ? 32'h0000_00FF : 32'hFFFF_FFFF;
        bb       = ts ? ~tb_v : tb_v;
        full     = {1'b0, ta & mask} + {1'b0, bb & mask} + (ts ? 33'd1 : {32'd0, tc});
        exp_sum  = full[31:0] & mask;
        exp_cout = sel ? full[8] : full[32];

        @(negedge clk);
        check("req_ready_idle", 64'(o_ready), 64'd1);
        a = ta; b = tb_v; cin = tc; sub = ts; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'b0;
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), sel ? 64'd1 : 64'd4);
        check("sum", 64'(o_sum), 64'(exp_sum));
        check("cout", 64'(o_cout), 64'(exp_cout));
        check("busy_done", 64'(o_busy), 64'd1);
        check("req_ready_done", 64'(o_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            vld = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
            check("hold_sum", 64'(o_sum), 64'(exp_sum));
            check("hold_cout", 64'(o_cout), 64'(exp_cout));
            check("hold_valid", 64'(o_valid), 64'd1);
            check("hold_ready", 64'(o_ready), 64'd0);
        end
        vld = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        check("valid_cleared", 64'(o_valid), 64'd0);
        check("req_ready_back", 64'(o_ready), 64'd1);
        check("busy_cleared", 64'(o_busy), 64'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_sum", 64'(bus4.res_sum), 64'd0);
        check("rst_cout", 64'(bus4.res_cout), 64'd0);
        check("rst_valid", 64'(bus4.res_valid), 64'd0);
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_ready", 64'(bus4.req_ready), 64'd1);
        check("rst_valid1", 64'(bus1.res_valid), 64'd0);
        check("rst_ready1", 64'(bus1.req_ready), 64'd1);
    endtask

    initial begin
        logic ts;
        #1 rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed 4-byte cases.
        sel = 1'b0;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 10);

        // Abort mid-RUN after two bytes have been processed.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);

`ifdef XC2_ADDSEQ_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 0);
        run_op(32'd7, 32'd5, 1'b1, 1'b1, 0);
`endif

        for (int k = 0; k < 16; k++) begin
            ts = 1'b0;
`ifdef XC2_ADDSEQ_SUB_EN
            ts = 1'($urandom_range(0, 1));
`endif
            run_op($urandom, $urandom, 1'($urandom), ts, int'($urandom_range(0, 2)));
        end

        // Single-byte instance.
        sel = 1'b1;
        run_op(32'h80, 32'h80, 1'b0, 1'b0, 0);
        run_op(32'hFF, 32'h00, 1'b1, 1'b0, 3);
        for (int k = 0; k < 8; k++) begin
            ts = 1'b0;
`ifdef XC2_ADDSEQ_SUB_EN
            ts = 1'($urandom_range(0, 1));
`endif
            run_op($urandom, $urandom, 1'($urandom), ts, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
